// File: rtl/nrad_seq_ctrl_pkg.sv
// Shared constants and state encoding for the sequential non-restoring divider.
//   DW : dividend / quotient width
//   VW : divisor / remainder width
//   PW : partial-remainder width (one sign bit above VW)
//   CW : iteration counter width
package nrad_seq_ctrl_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned PW = VW + 1;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/nrad_seq_ctrl_if.sv
// Operand / result handshake bundle for nrad_seq_ctrl.
//   start, X, Y          : request side (driven by the operand source)
//   busy, done, Q, R, dbz : result side (driven by the divider)
interface nrad_seq_ctrl_if;
  import nrad_seq_ctrl_pkg::*;

  logic          start;
  logic [DW-1:0] X;
  logic [VW-1:0] Y;
  logic          busy;
  logic          done;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          dbz;

  modport master (output start, X, Y, input busy, done, Q, R, dbz);
  modport slave  (input start, X, Y, output busy, done, Q, R, dbz);
endinterface

// File: rtl/nrad_seq_ctrl_cas_row.sv
// Single controlled add/subtract row, PW bits wide, modulo 2^PW.
//   a, b  : operands
//   sub   : 1 -> a - b, 0 -> a + b
//   res_c : combinational result
module nrad_seq_ctrl_cas_row
  import nrad_seq_ctrl_pkg::*;
(
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  input  logic          sub,
  output logic [PW-1:0] res_c
);

  assign res_c = sub ? (a - b) : (a + b);

endmodule

// File: rtl/nrad_seq_ctrl.sv
// Sequential non-restoring divider: one CAS row reused per quotient bit,
// followed by a fixed remainder-correction cycle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of nrad_seq_ctrl_if (start/X/Y in, busy/done/Q/R/dbz out)
module nrad_seq_ctrl
  import nrad_seq_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  nrad_seq_ctrl_if.slave bus
);

  state_t        state;
  logic [DW-1:0] a_q;
  logic [VW-1:0] d_q;
  logic [PW-1:0] p_q;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] r_q;
  logic          dbz_q;

  logic [PW-1:0] p_sh;
  logic [PW-1:0] cas_a;
  logic          cas_sub;
  logic [PW-1:0] cas_res;
  logic [PW-1:0] p_fix;

  // {P,A} shifted left by one: the P half for this iteration
  assign p_sh = {p_q[VW-1:0], a_q[DW-1]};

  // Row is shared: ITER adds/subtracts on the shifted P, CORR only adds D back
  always_comb begin
    cas_a   = p_q;
    cas_sub = 1'b0;
    if (state == ST_ITER) begin
      cas_a   = p_sh;
      cas_sub = ~p_q[VW];
    end
  end

  nrad_seq_ctrl_cas_row u_cas_row (
    .a     (cas_a),
    .b     ({1'b0, d_q}),
    .sub   (cas_sub),
    .res_c (cas_res)
  );

  // Correction only applies when the final partial remainder is negative
  assign p_fix = p_q[VW] ? cas_res : p_q;

  // Controller: state, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      d_q    <= '0;
      p_q    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.start) begin
            a_q <= bus.X;
            d_q <= bus.Y;
            p_q <= '0;
            cnt <= '0;
            if (bus.Y != '0) begin
              state  <= ST_ITER;
              busy_q <= 1'b1;
              dbz_q  <= 1'b0;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              q_q    <= '1;
              r_q    <= '0;
              dbz_q  <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          p_q <= cas_res;
          a_q <= {a_q[DW-2:0], ~cas_res[VW]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            state <= ST_CORR;
          end
        end
        ST_CORR: begin
          p_q    <= p_fix;
          q_q    <= a_q;
          r_q    <= p_fix[VW-1:0];
          state  <= ST_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_nrad_seq_ctrl.sv
// Self-checking bench for nrad_seq_ctrl: directed vector table, hand-written
// back-to-back and mid-operation reset sequences, and an exhaustive sweep.
module tb_nrad_seq_ctrl;

  logic clk;
  logic reset;

  nrad_seq_ctrl_if bus ();

  nrad_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [3:0] y;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t tbl [9];

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation; latency counts edges from acceptance to first done.
  task automatic run_op(input logic [7:0] x, input logic [3:0] y,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic dbz, output int lat, output logic busy_bad);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = x;
    bus.Y     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_bad  = 1'b0;
    while (!bus.done && lat < 30) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    q   = bus.Q;
    r   = bus.R;
    dbz = bus.dbz;
  endtask

  logic [7:0] q;
  logic [3:0] r;
  logic       dbz;
  int         lat;
  logic       busy_bad;
  logic       saw_done;
  int         sweep_err;

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
    n_vec     = 0;
    n_err     = 0;

    tbl[0] = '{x: 8'd100, y: 4'd7,  q: 8'd14,  r: 4'd2,  dbz: 1'b0, lat: 10};
    tbl[1] = '{x: 8'd255, y: 4'd15, q: 8'd17,  r: 4'd0,  dbz: 1'b0, lat: 10};
    tbl[2] = '{x: 8'd5,   y: 4'd9,  q: 8'd0,   r: 4'd5,  dbz: 1'b0, lat: 10};
    tbl[3] = '{x: 8'd37,  y: 4'd0,  q: 8'd255, r: 4'd0,  dbz: 1'b1, lat: 1};
    tbl[4] = '{x: 8'd0,   y: 4'd1,  q: 8'd0,   r: 4'd0,  dbz: 1'b0, lat: 10};
    tbl[5] = '{x: 8'd255, y: 4'd1,  q: 8'd255, r: 4'd0,  dbz: 1'b0, lat: 10};
    tbl[6] = '{x: 8'd14,  y: 4'd15, q: 8'd0,   r: 4'd14, dbz: 1'b0, lat: 10};
    tbl[7] = '{x: 8'd200, y: 4'd3,  q: 8'd66,  r: 4'd2,  dbz: 1'b0, lat: 10};
    tbl[8] = '{x: 8'd254, y: 4'd8,  q: 8'd31,  r: 4'd6,  dbz: 1'b0, lat: 10};

    // Reset state
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_q",    32'(bus.Q),    32'd0);
    check("rst_r",    32'(bus.R),    32'd0);
    check("rst_dbz",  32'(bus.dbz),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].x, tbl[i].y, q, r, dbz, lat, busy_bad);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d_q", i),   32'(q),   32'(tbl[i].q));
      check($sformatf("vec%0d_r", i),   32'(r),   32'(tbl[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(tbl[i].dbz));
      check($sformatf("vec%0d_busy", i), 32'(busy_bad), 32'd0);
    end

    // Back-to-back with start held; changes during busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 8'd200;
    bus.Y     = 4'd3;
    @(posedge clk);
    #1;
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_first_lat", 32'(lat),   32'd10);
    check("b2b_first_q",   32'(bus.Q), 32'd66);
    check("b2b_first_r",   32'(bus.R), 32'd2);
    @(posedge clk);
    #1;
    check("b2b_accept_busy", 32'(bus.busy), 32'd1);
    bus.X = 8'd9;
    bus.Y = 4'd2;
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_second_lat", 32'(lat),     32'd10);
    check("b2b_second_q",   32'(bus.Q),   32'd66);
    check("b2b_second_r",   32'(bus.R),   32'd2);
    check("b2b_second_dbz", 32'(bus.dbz), 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_idle_done", 32'(bus.done), 32'd0);
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 8'd100;
    bus.Y     = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_q",    32'(bus.Q),    32'd0);
    check("midrst_r",    32'(bus.R),    32'd0);
    check("midrst_dbz",  32'(bus.dbz),  32'd0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(8'd100, 8'd7, q, r, dbz, lat, busy_bad);
    check("midrst_after_lat", 32'(lat), 32'd10);
    check("midrst_after_q",   32'(q),   32'd14);
    check("midrst_after_r",   32'(r),   32'd2);

    // Exhaustive sweep against integer division
    sweep_err = 0;
    for (int x = 0; x < 256; x++) begin
      for (int y = 1; y < 16; y++) begin
        run_op(8'(x), 4'(y), q, r, dbz, lat, busy_bad);
        n_vec++;
        if (q !== 8'(x / y) || r !== 4'(x % y) || dbz !== 1'b0 || lat != 10 || busy_bad) begin
          n_err++;
          sweep_err++;
          if (sweep_err <= 10)
            $display("FAIL sweep x=%0d y=%0d: got q=%0d r=%0d dbz=%0d lat=%0d, expected q=%0d r=%0d dbz=0 lat=10",
                     x, y, q, r, dbz, lat, x / y, x % y);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
